// File: rtl/uart_rx_top_if.sv
// Receiver-side bundle for uart_rx_top: serial line and frame configuration in,
// recovered word, status pulses and busy out.
interface uart_rx_top_if #(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 6
);
   logic                      rx_in;
   logic [PRESCALE_WIDTH-1:0] prescale;
   logic                      par_en;
   logic                      par_type;
   logic [DATA_WIDTH-1:0]     p_data;
   logic                      data_valid;
   logic                      par_err;
   logic                      stop_err;
   logic                      busy;

   modport master (
      output rx_in, prescale, par_en, par_type,
      input  p_data, data_valid, par_err, stop_err, busy
   );

   modport slave (
      input  rx_in, prescale, par_en, par_type,
      output p_data, data_valid, par_err, stop_err, busy
   );
endinterface

// File: rtl/uart_rx_top.sv
// Oversampling UART receiver with 2-of-3 majority vote per bit, optional parity and error pulses.
// Define UART_RX_SYNC_EN to pass rx_in through a 2-flop synchronizer first.
module uart_rx_top #(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 6,
   parameter int BIT_CNT_WIDTH  = 4
) (
   input  logic          clk,
   input  logic          rst,
   uart_rx_top_if.slave  bus
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   localparam logic [PRESCALE_WIDTH-1:0] ONE  = PRESCALE_WIDTH'(1);
   localparam logic [PRESCALE_WIDTH-1:0] TWO  = PRESCALE_WIDTH'(2);
   localparam logic [BIT_CNT_WIDTH-1:0]  BONE = BIT_CNT_WIDTH'(1);
   localparam logic [BIT_CNT_WIDTH-1:0]  BLAST = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

   state_t                    state, state_nxt;
   logic                      rx_s, rx_prev, fell, edge_pend;
   logic [PRESCALE_WIDTH-1:0] p_lat, half, edge_cnt;
   logic                      par_en_lat, par_type_lat;
   logic [2:0]                smp;
   logic                      maj, bit_end, vote_pt;
   logic [DATA_WIDTH-1:0]     shreg;
   logic [BIT_CNT_WIDTH-1:0]  bit_cnt;
   logic                      par_bad;
   logic                      start_go, start_late, frame_end;

`ifdef UART_RX_SYNC_EN
   logic [1:0] sync;
   always_ff @(posedge clk) begin
      if (rst) sync <= 2'b11;
      else     sync <= {sync[0], bus.rx_in};
   end
   assign rx_s = sync[1];
`else
   assign rx_s = bus.rx_in;
`endif

   assign fell    = rx_prev & ~rx_s;
   assign half    = p_lat >> 1;
   assign bit_end = (edge_cnt == p_lat - ONE);
   assign vote_pt = (edge_cnt == half + TWO);
   assign maj     = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // A start edge seen during the last stop cycle is honoured one cycle late
   // with edge_cnt pre-advanced, so zero-idle frames keep their bit alignment.
   always_comb begin
      state_nxt  = state;
      start_go   = 1'b0;
      start_late = 1'b0;
      frame_end  = 1'b0;
      case (state)
         IDLE: begin
            if (fell) begin
               state_nxt = START;
               start_go  = 1'b1;
            end else if (edge_pend && !rx_s) begin
               state_nxt  = START;
               start_go   = 1'b1;
               start_late = 1'b1;
            end
         end
         START: begin
            if (vote_pt && maj) state_nxt = IDLE;
            else if (bit_end)   state_nxt = DATA;
         end
         DATA: begin
            if (bit_end && bit_cnt == BLAST) state_nxt = par_en_lat ? PARITY : STOP;
         end
         PARITY: begin
            if (bit_end) state_nxt = STOP;
         end
         STOP: begin
            if (bit_end) begin
               state_nxt = IDLE;
               frame_end = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_prev        <= 1'b1;
         edge_pend      <= 1'b0;
         p_lat          <= '0;
         par_en_lat     <= 1'b0;
         par_type_lat   <= 1'b0;
         edge_cnt       <= '0;
         bit_cnt        <= '0;
         smp            <= 3'b111;
         shreg          <= '0;
         par_bad        <= 1'b0;
         bus.p_data     <= '0;
         bus.data_valid <= 1'b0;
         bus.par_err    <= 1'b0;
         bus.stop_err   <= 1'b0;
         bus.busy       <= 1'b0;
      end else begin
         rx_prev        <= rx_s;
         edge_pend      <= frame_end & fell;
         bus.data_valid <= 1'b0;
         bus.par_err    <= 1'b0;
         bus.stop_err   <= 1'b0;
         bus.busy       <= (state_nxt != IDLE);
         if (start_go) begin
            p_lat        <= bus.prescale;
            par_en_lat   <= bus.par_en;
            par_type_lat <= bus.par_type;
            edge_cnt     <= start_late ? ONE : '0;
            bit_cnt      <= '0;
            par_bad      <= 1'b0;
         end else if (state != IDLE) begin
            edge_cnt <= (bit_end || state_nxt == IDLE) ? '0 : edge_cnt + ONE;
            if (edge_cnt == half - ONE) smp[0] <= rx_s;
            if (edge_cnt == half)       smp[1] <= rx_s;
            if (edge_cnt == half + ONE) smp[2] <= rx_s;
            if (bit_end) begin
               case (state)
                  DATA: begin
                     shreg   <= {maj, shreg[DATA_WIDTH-1:1]};
                     bit_cnt <= bit_cnt + BONE;
                  end
                  PARITY:  par_bad <= (maj != (par_type_lat ? ~^shreg : ^shreg));
                  default: ;
               endcase
            end
            // Stop error outranks parity error; only a clean frame updates p_data.
            if (frame_end) begin
               if (!maj)         bus.stop_err <= 1'b1;
               else if (par_bad) bus.par_err  <= 1'b1;
               else begin
                  bus.p_data     <= shreg;
                  bus.data_valid <= 1'b1;
               end
            end
         end
      end
   end
endmodule
